spi_exe_unit_p: RTL and testbench
=================================

// Module: spi_exe_unit_p
// PURPOSE
//  Parametrised SPI-slave execution unit; next generation of the 8-bit SPI ALU unit.
//  Runs on a system clock and oversamples SCLK/CS/MOSI, so SCLK is no longer a clock.
//  Each SPI frame carries {argA, argB, oper}. The ALU result, flags, frame status and a
//  sequence number are shifted out on MISO during the FOLLOWING frame.
//  Short or long frames are detected and reported.
// PARAMETERS
//  M      8  operand/result width (>=4)
//  N      4  opcode width (>=4; only oper[3:0] decoded, upper bits must be 0 else reserved)
//  SYNC   2  synchroniser flops on i_sclk/i_cs/i_mosi (>=2)
//  L      derived = 2*M+N, frame length in bits; SQ = L-M-5 = sequence field width (M+N>=6)
// PORTS
//  i_clk_p      in   1  system clock, >= 8x SCLK frequency
//  i_rst_n      in   1  synchronous active-low reset
//  i_sclk       in   1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
//  i_cs         in   1  SPI chip select, active low, asynchronous
//  i_mosi       in   1  SPI data in, MSB first
//  o_miso       out  1  SPI data out, MSB first; 0 while CS high
//  o_frame_done out  1  1-clk pulse: valid L-bit frame accepted and executed
//  o_frame_err  out  1  1-clk pulse: frame ended with bit count != L
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): all state cleared; o_miso=0, o_frame_done=0, o_frame_err=0.
//    Response register, seq counter, err bit and bit counter are all 0.
//  Inputs pass through SYNC flops; sclk/cs edges are detected on synchronised copies.
//  FSM IDLE -> SHIFT on cs fall: bit count=0; tx shift reg <= response word.
//    Response word is {res[M-1:0], flags[3:0], err, seq[SQ-1:0]}, width L.
//  SHIFT, sclk rise: rx <= {rx[L-2:0], mosi}; count++ (saturates at L+1).
//  SHIFT, sclk fall: tx <= tx<<1. o_miso = tx[L-1] while cs low, else 0.
//  SHIFT -> EXEC on cs rise.
//  EXEC, one clk, then IDLE:
//    count==L: decode rx as {A, B, op}. Register res/flags; err<=0; seq++ (wraps mod 2^SQ);
//      o_frame_done=1.
//    count!=L (including 0): res/flags/seq unchanged; err<=1; o_frame_err=1.
//  Latency: the result of frame k appears on MISO in frame k+1. The first frame after
//    reset returns all zeros.
//  Cs rise and cs fall detected in the same clk cannot occur (sync); min CS-high = 3 clk.
//  Sclk edges while cs high are ignored. Reset mid-frame aborts the frame; no result.
//  ALU (unsigned M-bit, wrap mod 2^M): 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A;
//    6 SHL A by B[log2M-1:0]; 7 SHR logical; 8 ASR; 9 INC A; 10 DEC A; 11 PASS B;
//    12-15 reserved -> res=0, flags=0.
//  flags[0] SF = res[M-1]; flags[1] OF = signed overflow (ADD/SUB/INC/DEC only, else 0);
//  flags[2] NF = (res==0); flags[3] BF = carry out (ADD/INC), borrow A<B (SUB),
//    A==0 (DEC), else 0. Reserved ops force all flags to 0.
// TESTING  (M=8, N=4, L=20, SQ=7; sysclk=10x sclk)
//  1 reset, frame A=7F B=01 op=0, then frame NOP-data -> 2nd MISO=80,F=0011,err0,seq1;
//    1st MISO all 0.
//  2 SUB A=00 B=01 -> res FF, SF=1 BF=1 OF=0 NF=0; then SUB 80-01 -> res 7F, OF=1, SF=0.
//  3 12-bit short frame after a valid frame -> o_frame_err pulse.
//    Next response = previous res/flags, err=1, seq unchanged.
//    Following valid frame clears err.
//  4 SHL A=81 B=03 -> 08; ASR A=80 B=07 -> FF; op=12 -> res 00, flags 0000.
//  5 128 back-to-back valid frames, min CS-high gap -> seq wraps 7F->00; 128 done pulses.
//  6 i_rst_n low at bit 10 of a frame -> no done/err pulse; next response all 0; o_miso=0.

Source files
------------

// File: rtl/spi_exe_unit_p.sv
// spi_exe_unit_p: oversampled SPI-slave ALU; frame k's result, flags, status and sequence number shift out during frame k+1
module spi_exe_unit_p #(
  parameter int M = 8,
  parameter int N = 4,
  parameter int SYNC = 2
) (
  input  logic i_clk_p,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_frame_done,
  output logic o_frame_err
);
  localparam int L = 2*M+N;
  localparam int SQ = L-M-5;
  localparam int CW = $clog2(L+2);
  localparam int SW = $clog2(M);
  typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_t;
  state_t state, next;
  logic [SYNC-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d;
  logic [CW-1:0] cnt;
  logic [L-1:0] rx, tx;
  logic [M-1:0] res, a, b, alu_res;
  logic [3:0] flags, alu_flags;
  logic err;
  logic [SQ-1:0] seq;
  logic [N-1:0] op;
  logic [SW-1:0] sh;
  logic [M:0] wide;
  logic bf, of, rsv;
  wire sclk_s = sclk_q[SYNC-1];
  wire cs_s = cs_q[SYNC-1];
  wire sclk_rise = sclk_s & ~sclk_d;
  wire sclk_fall = ~sclk_s & sclk_d;
  wire cs_rise = cs_s & ~cs_d;
  wire cs_fall = ~cs_s & cs_d;
  wire full = cnt == CW'(L);
  assign a = rx[L-1 -: M];
  assign b = rx[M+N-1 -: M];
  assign op = rx[N-1:0];
  assign sh = b[SW-1:0];
  // Synchronisers clear to 0 so a CS already low at reset release never looks like a fresh frame start
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      sclk_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC-2:0], i_sclk};
      cs_q <= {cs_q[SYNC-2:0], i_cs};
      mosi_q <= {mosi_q[SYNC-2:0], i_mosi};
      sclk_d <= sclk_s;
      cs_d <= cs_s;
    end
  end
  always_ff @(posedge i_clk_p) state <= !i_rst_n ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = cs_fall ? SHIFT : IDLE;
      SHIFT: next = cs_rise ? EXEC : SHIFT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      cnt <= '0;
      rx <= '0;
      tx <= '0;
      res <= '0;
      flags <= '0;
      err <= 1'b0;
      seq <= '0;
    end else begin
      if (state == IDLE && cs_fall) begin
        cnt <= '0;
        tx <= {res, flags, err, seq};
      end
      if (state == SHIFT && sclk_rise) begin
        rx <= {rx[L-2:0], mosi_q[SYNC-1]};
        cnt <= cnt == CW'(L+1) ? cnt : cnt + 1'b1;
      end
      if (state == SHIFT && sclk_fall) tx <= tx << 1;
      if (state == EXEC && full) begin
        res <= alu_res;
        flags <= alu_flags;
        err <= 1'b0;
        seq <= seq + 1'b1;
      end
      if (state == EXEC && !full) err <= 1'b1;
    end
  end
  always_comb begin
    wide = '0;
    bf = 1'b0;
    of = 1'b0;
    rsv = (op >> 4) != '0;
    case (op[3:0])
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        bf = wide[M];
        of = (a[M-1] == b[M-1]) && (wide[M-1] != a[M-1]);
      end
      4'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        bf = a < b;
        of = (a[M-1] != b[M-1]) && (wide[M-1] != a[M-1]);
      end
      4'd2: wide = {1'b0, a & b};
      4'd3: wide = {1'b0, a | b};
      4'd4: wide = {1'b0, a ^ b};
      4'd5: wide = {1'b0, ~a};
      4'd6: wide = {1'b0, a << sh};
      4'd7: wide = {1'b0, a >> sh};
      4'd8: wide = {1'b0, $signed(a) >>> sh};
      4'd9: begin
        wide = {1'b0, a} + {{M{1'b0}}, 1'b1};
        bf = wide[M];
        of = ~a[M-1] & wide[M-1];
      end
      4'd10: begin
        wide = {1'b0, a} - {{M{1'b0}}, 1'b1};
        bf = a == '0;
        of = a[M-1] & ~wide[M-1];
      end
      4'd11: wide = {1'b0, b};
      default: rsv = 1'b1;
    endcase
    alu_res = rsv ? '0 : wide[M-1:0];
    alu_flags = rsv ? 4'd0 : {bf, alu_res == '0, of, alu_res[M-1]};
  end
  assign o_miso = state == SHIFT && !cs_s && tx[L-1];
  assign o_frame_done = state == EXEC && full;
  assign o_frame_err = state == EXEC && !full;
endmodule

// File: tb/tb_spi_exe_unit_p.sv
// tb_spi_exe_unit_p: random and directed SPI frames checked against an integer-arithmetic model of the response word
module tb_spi_exe_unit_p;
  localparam int L = 20;
  logic clk = 0, rst_n = 0, sclk = 0, cs = 1, mosi = 0;
  logic miso, done, err;
  int checks = 0, failures = 0, done_n = 0, err_n = 0;
  int m_res = 0, m_flags = 0, m_err = 0, m_seq = 0;
  logic [L-1:0] got;
  spi_exe_unit_p dut (
    .i_clk_p(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_frame_done(done), .o_frame_err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (done) done_n++;
    if (err) err_n++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic d, output logic m);
    mosi = d;
    repeat (5) @(negedge clk);
    sclk = 1;
    m = miso;
    repeat (5) @(negedge clk);
    sclk = 0;
  endtask
  task automatic model_exec(input int a, input int b, input int op);
    int r, sa, sb, sr, sh;
    logic bf, of;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    sh = b % 8;
    bf = 0;
    of = 0;
    r = 0;
    case (op)
      0: begin r = a + b; bf = r > 255; sr = sa + sb; of = sr > 127 || sr < -128; end
      1: begin r = a - b; bf = a < b; sr = sa - sb; of = sr > 127 || sr < -128; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a << sh;
      7: r = a >> sh;
      8: begin sr = sa >>> sh; r = sr; end
      9: begin r = a + 1; bf = r > 255; of = sa + 1 > 127; end
      10: begin r = a - 1; bf = a == 0; of = sa - 1 < -128; end
      11: r = b;
      default: r = 0;
    endcase
    r = r & 255;
    m_res = r;
    m_flags = op > 11 ? 0 : {bf, r == 0, of, r > 127};
    m_err = 0;
    m_seq = (m_seq + 1) % 128;
  endtask
  task automatic run(input int nbits, input int a, input int b, input int op, input int gap, output logic [L-1:0] resp);
    logic [31:0] w;
    logic [L-1:0] exp;
    logic m;
    int d0, e0;
    w = (a << 12) | (b << 4) | op;
    if (nbits > L) w = (w << (nbits - L)) | ($urandom & ((1 << (nbits - L)) - 1));
    if (nbits < L) w = w >> (L - nbits);
    exp = {m_res[7:0], m_flags[3:0], m_err[0], m_seq[6:0]};
    d0 = done_n;
    e0 = err_n;
    resp = '0;
    @(negedge clk) cs = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[nbits-1-i], m);
      if (i < L) resp[L-1-i] = m;
    end
    repeat (5) @(negedge clk);
    cs = 1;
    repeat (gap) @(negedge clk);
    if (nbits >= L) check("resp", resp, exp);
    if (gap >= 6) begin
      check("done_pulse", done_n - d0, nbits == L);
      check("err_pulse", err_n - e0, nbits != L);
      check("miso_idle", miso, 0);
    end
    if (nbits == L) model_exec(a, b, op);
    else m_err = 1;
  endtask
  initial begin
    int d0, e0, n, op;
    logic m;
    repeat (4) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    repeat (4) @(negedge clk);
    run(L, 'h7F, 'h01, 0, 8, got);
    check("t1_first_zero", got, 0);
    run(L, 0, 0, 11, 8, got);
    check("t1_add_resp", got, {8'h80, 4'b0011, 1'b0, 7'd1});
    run(L, 'h00, 'h01, 1, 8, got);
    run(L, 'h80, 'h01, 1, 8, got);
    check("t2_sub_borrow", got[19:8], {8'hFF, 4'b1001});
    run(12, 'h12, 'h34, 2, 8, got);
    run(L, 'h55, 'h0F, 4, 8, got);
    check("t3_err_set", got, {8'h7F, 4'b0010, 1'b1, 7'd4});
    run(L, 'h81, 'h03, 6, 8, got);
    check("t3_err_clear", got[7], 0);
    run(L, 'h80, 'h07, 8, 8, got);
    check("t4_shl", got[19:12], 'h08);
    run(L, 'hAA, 'h55, 12, 8, got);
    check("t4_asr", got[19:12], 'hFF);
    run(L + 2, 0, 0, 0, 8, got);
    check("t4_rsv", got[19:8], 0);
    d0 = done_n;
    for (int i = 0; i < 128; i++) run(L, $urandom_range(255), $urandom_range(255), $urandom_range(11), 3, got);
    repeat (8) @(negedge clk);
    check("t5_done_count", done_n - d0, 128);
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(7) == 0 ? L - 3 + 5 * $urandom_range(1) : L;
      op = $urandom_range(15);
      run(n, $urandom_range(255), $urandom_range(255), op, 8, got);
    end
    d0 = done_n;
    e0 = err_n;
    @(negedge clk) cs = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) send_bit($urandom_range(1), m);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("t6_miso_after_rst", miso, 0);
    for (int i = 0; i < 10; i++) send_bit($urandom_range(1), m);
    repeat (5) @(negedge clk);
    cs = 1;
    repeat (10) @(negedge clk);
    check("t6_no_done", done_n - d0, 0);
    check("t6_no_err", err_n - e0, 0);
    m_res = 0;
    m_flags = 0;
    m_err = 0;
    m_seq = 0;
    run(L, 'h10, 'h20, 0, 8, got);
    check("t6_resp_zero", got, 0);
    run(L, 0, 0, 11, 8, got);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #20ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
